acc_result_axi_writer: RTL and testbench

- Write-direction counterpart of the DMA-to-accelerator read stream.
- Accepts accelerator result words on a valid/ready stream and buffers them in an internal FIFO.
- Writes the words to system RAM as AXI4 INCR write bursts, starting at a CPU-programmed base address, for a programmed byte count.
- Sits beside the DMA wrapper on the system AXI4 master fabric; reports busy, done and error status for CSR readback.

---
 rtl/acc_result_axi_writer.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_acc_result_axi_writer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_result_axi_writer.sv
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 32
`endif

package acc_axi_pkg;
    localparam int AXI_DATA_W = `DMA_DATA_WIDTH;
    localparam int AXI_ADDR_W = `DMA_ADDR_WIDTH;
    localparam int AXI_ID_W   = 4;

    typedef struct packed {
        logic [AXI_ID_W-1:0]     awid;
        logic [AXI_ADDR_W-1:0]   awaddr;
        logic [7:0]              awlen;
        logic [2:0]              awsize;
        logic [1:0]              awburst;
        logic                    awvalid;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
        logic                    wvalid;
        logic                    bready;
        logic [AXI_ID_W-1:0]     arid;
        logic [AXI_ADDR_W-1:0]   araddr;
        logic [7:0]              arlen;
        logic [2:0]              arsize;
        logic [1:0]              arburst;
        logic                    arvalid;
        logic                    rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [AXI_ID_W-1:0]   bid;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic                  arready;
        logic [AXI_ID_W-1:0]   rid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
        logic                  rvalid;
    } s_axi_miso_t;
endpackage

// Generic synchronous FIFO with flush; pop data is visible the cycle after push.
// Backpressure: push_rdy_o low when full, pop_vld_o low when empty.
module acc_result_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_vld_i,
    input  logic [W-1:0]  push_dat_i,
    output logic          push_rdy_o,
    output logic          pop_vld_o,
    output logic [W-1:0]  pop_dat_o,
    input  logic          pop_rdy_i,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;

    assign push_rdy_o = (count_q != CW'(DEPTH));
    assign pop_vld_o  = (count_q != '0);
    assign pop_dat_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign push       = push_vld_i & push_rdy_o;
    assign pop        = pop_rdy_i & pop_vld_o;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
endmodule

// Buffers accelerator results and writes them to RAM as 4 KB-safe AXI4 INCR bursts.
// One burst outstanding; acc_ready_o drops when the FIFO is full or all words are taken.
module acc_result_axi_writer
    import acc_axi_pkg::*;
#(
    parameter int DATA_W     = `DMA_DATA_WIDTH,
    parameter int ADDR_W     = `DMA_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 16,
    parameter int AXI_ID_VAL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start_i,
    input  logic [ADDR_W-1:0] cfg_base_addr_i,
    input  logic [ADDR_W-1:0] cfg_num_bytes_i,
    input  logic              cfg_abort_i,
    input  logic [DATA_W-1:0] acc_data_i,
    input  logic              acc_valid_i,
    output logic              acc_ready_o,
    output s_axi_mosi_t       axi_mosi_o,
    input  s_axi_miso_t       axi_miso_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] error_addr_o
);
    localparam int BPW    = DATA_W / 8;
    localparam int BPW_LG = $clog2(BPW);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BPW - 1);
    localparam logic [2:0]        AW_SIZE    = 3'(BPW_LG);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_AW, S_W, S_B} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, acc_left_q, acc_left_d, wr_left_q, wr_left_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [8:0]        blen_q, blen_d;
    logic [7:0]        beat_q, beat_d;
    logic              done_q, done_d, error_q, error_d;

    logic              fifo_rdy, fifo_vld, fifo_pop, fifo_flush, acc_push, cfg_ok;
    logic [DATA_W-1:0] fifo_dat;
    logic [CW-1:0]     fifo_count;
    logic [ADDR_W-1:0] page_room, burst_len;
    logic              unused_miso;

    assign unused_miso = ^{axi_miso_i.bid, axi_miso_i.arready, axi_miso_i.rid,
                           axi_miso_i.rdata, axi_miso_i.rresp, axi_miso_i.rlast,
                           axi_miso_i.rvalid};

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign error_addr_o = err_addr_q;
    assign acc_ready_o  = busy_o & fifo_rdy & (acc_left_q != '0);
    assign acc_push     = acc_valid_i & acc_ready_o;
    assign fifo_pop     = (state_q == S_W) & fifo_vld & axi_miso_i.wready;
    // Any return to IDLE drops leftover words so the next transfer starts clean.
    assign fifo_flush   = (state_d == S_IDLE) & (state_q != S_IDLE);

    assign cfg_ok = (cfg_num_bytes_i != '0) && ((cfg_num_bytes_i & ALIGN_MASK) == '0)
                 && ((cfg_base_addr_i & ALIGN_MASK) == '0);

    acc_result_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (fifo_flush),
        .push_vld_i (acc_push),
        .push_dat_i (acc_data_i),
        .push_rdy_o (fifo_rdy),
        .pop_vld_o  (fifo_vld),
        .pop_dat_o  (fifo_dat),
        .pop_rdy_i  (fifo_pop),
        .count_o    (fifo_count)
    );

    assign page_room = ADDR_W'((13'd4096 - {1'b0, addr_q[11:0]}) >> BPW_LG);

    always_comb begin
        burst_len = wr_left_q;
        if (burst_len > ADDR_W'(MAX_BURST)) burst_len = ADDR_W'(MAX_BURST);
        if (burst_len > page_room)          burst_len = page_room;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        acc_left_d = acc_left_q;
        wr_left_d  = wr_left_q;
        err_addr_d = err_addr_q;
        blen_d     = blen_q;
        beat_d     = beat_q;
        done_d     = done_q;
        error_d    = error_q;
        if (acc_push) acc_left_d = acc_left_q - 1'b1;
        case (state_q)
            S_IDLE: begin
                if (cfg_start_i) begin
                    if (cfg_ok) begin
                        state_d    = S_WAIT;
                        addr_d     = cfg_base_addr_i;
                        acc_left_d = cfg_num_bytes_i >> BPW_LG;
                        wr_left_d  = cfg_num_bytes_i >> BPW_LG;
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                    end else begin
                        error_d    = 1'b1;
                        done_d     = 1'b1;
                        err_addr_d = cfg_base_addr_i;
                    end
                end
            end
            S_WAIT: begin
                if (cfg_abort_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (ADDR_W'(fifo_count) >= burst_len) begin
                    blen_d  = burst_len[8:0];
                    beat_d  = 8'(burst_len - 1'b1);
                    state_d = S_AW;
                end
            end
            S_AW: if (axi_miso_i.awready) state_d = S_W;
            S_W: begin
                if (fifo_pop) begin
                    beat_d = beat_q - 1'b1;
                    if (beat_q == '0) state_d = S_B;
                end
            end
            S_B: begin
                if (axi_miso_i.bvalid) begin
                    if (axi_miso_i.bresp != 2'b00) begin
                        error_d    = 1'b1;
                        err_addr_d = addr_q;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        addr_d    = addr_q + (ADDR_W'(blen_q) << BPW_LG);
                        wr_left_d = wr_left_q - ADDR_W'(blen_q);
                        if ((wr_left_q == ADDR_W'(blen_q)) || cfg_abort_i) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fifo_flush) acc_left_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            acc_left_q <= '0;
            wr_left_q  <= '0;
            err_addr_q <= '0;
            blen_q     <= '0;
            beat_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            acc_left_q <= acc_left_d;
            wr_left_q  <= wr_left_d;
            err_addr_q <= err_addr_d;
            blen_q     <= blen_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Request fields are gated by state so the bus idles at all-zero.
    always_comb begin
        axi_mosi_o      = '0;
        axi_mosi_o.awid = AXI_ID_W'(AXI_ID_VAL);
        if (state_q == S_AW) begin
            axi_mosi_o.awaddr  = addr_q;
            axi_mosi_o.awlen   = 8'(blen_q - 9'd1);
            axi_mosi_o.awsize  = AW_SIZE;
            axi_mosi_o.awburst = 2'b01;
            axi_mosi_o.awvalid = 1'b1;
        end
        if (state_q == S_W) begin
            axi_mosi_o.wdata  = fifo_dat;
            axi_mosi_o.wstrb  = '1;
            axi_mosi_o.wlast  = (beat_q == '0);
            axi_mosi_o.wvalid = fifo_vld;
        end
        axi_mosi_o.bready = (state_q == S_B);
    end
endmodule

// File: tb/tb_acc_result_axi_writer.sv
module tb_acc_result_axi_writer;
    import acc_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_base = '0;
    logic [31:0] cfg_bytes = '0;
    logic        cfg_abort = 1'b0;
    logic [31:0] acc_data = '0;
    logic        acc_valid = 1'b0;
    logic        acc_ready;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;
    logic        busy, done, error;
    logic [31:0] error_addr;

    acc_result_axi_writer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start_i     (cfg_start),
        .cfg_base_addr_i (cfg_base),
        .cfg_num_bytes_i (cfg_bytes),
        .cfg_abort_i     (cfg_abort),
        .acc_data_i      (acc_data),
        .acc_valid_i     (acc_valid),
        .acc_ready_o     (acc_ready),
        .axi_mosi_o      (mosi),
        .axi_miso_i      (miso),
        .busy_o          (busy),
        .done_o          (done),
        .error_o         (error),
        .error_addr_o    (error_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave-side and scoreboard state
    logic [31:0] mem [logic [31:0]];
    logic [31:0] aw_addr_log[$];
    int          aw_len_log[$];
    int          cfg_awdly = 0;
    bit          cfg_wrand = 0;
    int          cfg_err_burst = 0;
    int          aw_count = 0;
    int          aw_stall = 0;
    int          n_beats = 0;
    int          wbeat = 0;
    int          tb_cnt = 0;
    bit          full_seen = 0;
    bit          have_prev = 0;
    bit          b_pend = 0;
    bit          b_hs = 0;
    bit          stop_stream = 0;
    logic [31:0] cur_addr = '0;
    int          cur_len = 0;
    logic [31:0] prev_awaddr = '0;
    logic [7:0]  prev_awlen = '0;
    logic [31:0] word_base = '0;

    // AXI write slave and monitor: observe at negedge, drive at posedge+1.
    initial begin
        miso = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy && tb_cnt == 16) begin
                    chk("ready_low_when_full", 32'(acc_ready), 32'd0);
                    full_seen = 1;
                end
                if (acc_valid && acc_ready) tb_cnt++;
                if (mosi.awvalid && miso.awready) begin
                    aw_addr_log.push_back(mosi.awaddr);
                    aw_len_log.push_back(int'(mosi.awlen));
                    cur_addr = mosi.awaddr;
                    cur_len = int'(mosi.awlen);
                    wbeat = 0;
                    aw_count++;
                    aw_stall = 0;
                    have_prev = 0;
                end else if (mosi.awvalid) begin
                    if (have_prev) begin
                        chk("awaddr_stable", mosi.awaddr, prev_awaddr);
                        chk("awlen_stable", 32'(mosi.awlen), 32'(prev_awlen));
                    end
                    prev_awaddr = mosi.awaddr;
                    prev_awlen = mosi.awlen;
                    have_prev = 1;
                end
                if (mosi.wvalid && miso.wready) begin
                    chk("wlast", 32'(mosi.wlast), 32'(wbeat == cur_len));
                    chk("wdata_order", mosi.wdata, word_base + 32'(n_beats));
                    mem[cur_addr + 32'(wbeat * 4)] = mosi.wdata;
                    wbeat++;
                    n_beats++;
                    tb_cnt--;
                    if (mosi.wlast) b_pend = 1;
                end
                if (mosi.bready && miso.bvalid) begin
                    b_pend = 0;
                    b_hs = 1;
                end
            end
            @(posedge clk);
            #1;
            if (mosi.awvalid) begin
                miso.awready = (aw_stall >= cfg_awdly);
                aw_stall++;
            end else begin
                miso.awready = 1'b0;
                aw_stall = 0;
            end
            miso.wready = cfg_wrand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_hs) begin
                miso.bvalid = 1'b0;
                b_hs = 0;
            end else if (b_pend) begin
                miso.bvalid = 1'b1;
                miso.bresp = (aw_count == cfg_err_burst) ? 2'b10 : 2'b00;
            end
        end
    end

    task automatic drive_stream(input int n, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 2000 && !stop_stream) begin
            @(posedge clk);
            #1;
            if (gaps && $urandom_range(0, 2) == 0) begin
                acc_valid = 1'b0;
            end else begin
                acc_valid = 1'b1;
                acc_data = word_base + 32'(i);
            end
            @(negedge clk);
            if (acc_valid && acc_ready) i++;
            guard++;
        end
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [31:0] bytes);
        @(posedge clk);
        #1;
        cfg_base = base;
        cfg_bytes = bytes;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] bytes;
        bit          bad_cfg;
        bit          gaps;
        int          awdly;
        bit          wrand;
        int          err_burst;
        bit          exp_err;
        logic [31:0] exp_eaddr;
        int          exp_naw;
        logic [31:0] aw0_addr;
        int          aw0_len;
        logic [31:0] awl_addr;
        int          awl_len;
        int          exp_beats;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        aw_addr_log.delete();
        aw_len_log.delete();
        mem.delete();
        n_beats = 0;
        tb_cnt = 0;
        aw_count = 0;
        full_seen = 0;
        stop_stream = 0;
        cfg_awdly = v.awdly;
        cfg_wrand = v.wrand;
        cfg_err_burst = v.err_burst;
        word_base = 32'hD000_0000 | (32'(idx) << 16);
        pulse_start(v.base, v.bytes);
        if (v.bad_cfg) begin
            chk($sformatf("v%0d_cfgerr_error", idx), 32'(error), 32'd1);
            chk($sformatf("v%0d_cfgerr_done", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d_cfgerr_busy", idx), 32'(busy), 32'd0);
        end else begin
            chk($sformatf("v%0d_start_busy", idx), 32'(busy), 32'd1);
            chk($sformatf("v%0d_start_done_clr", idx), 32'(done), 32'd0);
            chk($sformatf("v%0d_start_err_clr", idx), 32'(error), 32'd0);
        end
        fork
            drive_stream(v.bad_cfg ? 0 : int'(v.bytes / 4), v.gaps);
            begin
                wait_done();
                stop_stream = 1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_error", idx), 32'(error), 32'(v.exp_err));
        if (v.exp_err) chk($sformatf("v%0d_error_addr", idx), error_addr, v.exp_eaddr);
        chk($sformatf("v%0d_acc_ready", idx), 32'(acc_ready), 32'd0);
        chk($sformatf("v%0d_num_aw", idx), 32'(aw_addr_log.size()), 32'(v.exp_naw));
        chk($sformatf("v%0d_num_beats", idx), 32'(n_beats), 32'(v.exp_beats));
        if (v.exp_naw > 0 && aw_addr_log.size() > 0) begin
            chk($sformatf("v%0d_aw0_addr", idx), aw_addr_log[0], v.aw0_addr);
            chk($sformatf("v%0d_aw0_len", idx), 32'(aw_len_log[0]), 32'(v.aw0_len));
            chk($sformatf("v%0d_awl_addr", idx), aw_addr_log[$], v.awl_addr);
            chk($sformatf("v%0d_awl_len", idx), 32'(aw_len_log[$]), 32'(v.awl_len));
        end
        for (int i = 0; i < v.exp_beats; i++) begin
            logic [31:0] a;
            a = v.base + 32'(i * 4);
            chk($sformatf("v%0d_mem_%0h", idx, a), mem.exists(a) ? mem[a] : 32'hDEAD_BEEF,
                word_base + 32'(i));
        end
        if (v.gaps) chk($sformatf("v%0d_fifo_full_seen", idx), 32'(full_seen), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{base:32'h1000, bytes:64, bad_cfg:0, gaps:0, awdly:0, wrand:0, err_burst:0,
                    exp_err:0, exp_eaddr:0, exp_naw:1, aw0_addr:32'h1000, aw0_len:15,
                    awl_addr:32'h1000, awl_len:15, exp_beats:16};
        vecs[1] = '{base:32'h1FF8, bytes:32, bad_cfg:0, gaps:0, awdly:0, wrand:0, err_burst:0,
                    exp_err:0, exp_eaddr:0, exp_naw:2, aw0_addr:32'h1FF8, aw0_len:1,
                    awl_addr:32'h2000, awl_len:5, exp_beats:8};
        vecs[2] = '{base:32'h3000, bytes:128, bad_cfg:0, gaps:1, awdly:3, wrand:1, err_burst:0,
                    exp_err:0, exp_eaddr:0, exp_naw:2, aw0_addr:32'h3000, aw0_len:15,
                    awl_addr:32'h3040, awl_len:15, exp_beats:32};
        vecs[3] = '{base:32'h0, bytes:160, bad_cfg:0, gaps:0, awdly:1, wrand:0, err_burst:2,
                    exp_err:1, exp_eaddr:32'h40, exp_naw:2, aw0_addr:32'h0, aw0_len:15,
                    awl_addr:32'h40, awl_len:15, exp_beats:32};
        vecs[4] = '{base:32'h100, bytes:6, bad_cfg:1, gaps:0, awdly:0, wrand:0, err_burst:0,
                    exp_err:1, exp_eaddr:32'h100, exp_naw:0, aw0_addr:0, aw0_len:0,
                    awl_addr:0, awl_len:0, exp_beats:0};
        vecs[5] = '{base:32'h2, bytes:16, bad_cfg:1, gaps:0, awdly:0, wrand:0, err_burst:0,
                    exp_err:1, exp_eaddr:32'h2, exp_naw:0, aw0_addr:0, aw0_len:0,
                    awl_addr:0, awl_len:0, exp_beats:0};
        vecs[6] = '{base:32'h40, bytes:0, bad_cfg:1, gaps:0, awdly:0, wrand:0, err_burst:0,
                    exp_err:1, exp_eaddr:32'h40, exp_naw:0, aw0_addr:0, aw0_len:0,
                    awl_addr:0, awl_len:0, exp_beats:0};
        vecs[7] = '{base:32'h4000, bytes:64, bad_cfg:0, gaps:1, awdly:1, wrand:1, err_burst:0,
                    exp_err:0, exp_eaddr:0, exp_naw:1, aw0_addr:32'h4000, aw0_len:15,
                    awl_addr:32'h4000, awl_len:15, exp_beats:16};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_error_addr", error_addr, 32'd0);
        chk("rst_acc_ready", 32'(acc_ready), 32'd0);
        chk("rst_mosi_zero", 32'(mosi == '0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Abort while waiting for a full burst, error flag left over from the last bad start.
        aw_addr_log.delete();
        tb_cnt = 0;
        stop_stream = 0;
        cfg_wrand = 0;
        word_base = 32'hAB00_0000;
        pulse_start(32'h4000, 32'd64);
        drive_stream(5, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_busy", 32'(busy), 32'd1);
        chk("abort_pre_ready", 32'(acc_ready), 32'd1);
        cfg_abort = 1'b1;
        @(posedge clk);
        #1;
        cfg_abort = 1'b0;
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        chk("abort_acc_ready", 32'(acc_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_aw", 32'(aw_addr_log.size()), 32'd0);

        // Restart after abort: stale words must not appear in the new burst.
        run_vec(vecs[7], 7);

        // Asynchronous reset while a burst request is pending.
        stop_stream = 0;
        cfg_awdly = 20;
        word_base = 32'h5500_0000;
        pulse_start(32'h5000, 32'd64);
        fork
            drive_stream(16, 0);
            begin
                int cyc = 0;
                while (!mosi.awvalid && cyc < 500) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                chk("arst_saw_awvalid", 32'(mosi.awvalid), 32'd1);
                #2;
                rst_n = 1'b0;
                #1;
                chk("arst_busy", 32'(busy), 32'd0);
                chk("arst_awvalid", 32'(mosi.awvalid), 32'd0);
                chk("arst_done", 32'(done), 32'd0);
                chk("arst_acc_ready", 32'(acc_ready), 32'd0);
                stop_stream = 1;
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
